// File: rtl/sm_word_serializer.sv
// Sign/magnitude word serializer: sends sign, then WIDTH magnitude bits over a valid/ready link.
// Optional even-parity trailer bit when SM_SER_PARITY_EN is defined.
module sm_word_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             sign_i,
    input  logic             load_i,
    output logic             load_ready_o,
    output logic             ser_bit_o,
    output logic             ser_valid_o,
    input  logic             ser_ready_i,
    output logic             ser_last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SIGN = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_PAR  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sign_q, sign_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load_ready_q;
    logic             done_q, done_d;
`ifdef SM_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept, load_acc, last_data;

    assign ser_valid_o  = (state_q != S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign load_ready_o = load_ready_q;
    assign done_o       = done_q;
    assign accept       = ser_valid_o & ser_ready_i;
    assign load_acc     = load_i & load_ready_q;
    assign last_data    = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef SM_SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_acc) begin
                    shreg_d = data_i;
                    sign_d  = sign_i;
                    cnt_d   = '0;
`ifdef SM_SER_PARITY_EN
                    par_d   = ^{sign_i, data_i};
`endif
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (accept) state_d = S_DATA;
            end
            S_DATA: begin
                if (accept) begin
                    // Shift so the next bit to send always sits at the output end
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    if (last_data) begin
                        cnt_d = '0;
`ifdef SM_SER_PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
`ifdef SM_SER_PARITY_EN
                if (accept) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
        endcase
    end

    always_comb begin
        ser_bit_o = 1'b0;
        case (state_q)
            S_SIGN:  ser_bit_o = sign_q;
            S_DATA:  ser_bit_o = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef SM_SER_PARITY_EN
            S_PAR:   ser_bit_o = par_q;
`endif
            default: ser_bit_o = 1'b0;
        endcase
    end

`ifdef SM_SER_PARITY_EN
    assign ser_last_o = (state_q == S_PAR);
`else
    assign ser_last_o = (state_q == S_DATA) && last_data;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            sign_q       <= 1'b0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            sign_q       <= sign_d;
            cnt_q        <= cnt_d;
            // Registered ready: the final-accept cycle still reports busy
            load_ready_q <= (state_d == S_IDLE);
            done_q       <= done_d;
        end
    end

`ifdef SM_SER_PARITY_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) par_q <= 1'b0;
        else         par_q <= par_d;
    end
`endif

endmodule

// File: tb/tb_sm_word_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first instance share stimulus; expected
// bit streams are queued at load and popped as serial bits are accepted.
module tb_sm_word_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       sign, load, rdy;
    logic [1:0] lr, sb, sv, sl, bz, dn;

    int nvec = 0;
    int nerr = 0;

`ifdef SM_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic [1:0] sbq [2][$];   // {bit, last}
    logic       exp_done [2];
    logic       hold_v   [2];
    logic       hold_b   [2];

    always #5 clk = ~clk;

    sm_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk_i(clk), .reset_i(rst), .data_i(data), .sign_i(sign), .load_i(load),
        .load_ready_o(lr[0]), .ser_bit_o(sb[0]), .ser_valid_o(sv[0]), .ser_ready_i(rdy),
        .ser_last_o(sl[0]), .busy_o(bz[0]), .done_o(dn[0]));

    sm_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk_i(clk), .reset_i(rst), .data_i(data), .sign_i(sign), .load_i(load),
        .load_ready_o(lr[1]), .ser_bit_o(sb[1]), .ser_valid_o(sv[1]), .ser_ready_i(rdy),
        .ser_last_o(sl[1]), .busy_o(bz[1]), .done_o(dn[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        logic p;
        p = ^{s, d};
        sbq[0].push_back({s, 1'b0});
        sbq[1].push_back({s, 1'b0});
        for (int i = 0; i < 8; i++) begin
            sbq[0].push_back({d[i],   (PAR == 0) && (i == 7)});
            sbq[1].push_back({d[7-i], (PAR == 0) && (i == 7)});
        end
        if (PAR != 0) begin
            sbq[0].push_back({p, 1'b1});
            sbq[1].push_back({p, 1'b1});
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                sbq[j].delete();
                exp_done[j] = 1'b0;
                hold_v[j]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("done%0d", i), dn[i], exp_done[i]);
                exp_done[i] = 1'b0;
                if (hold_v[i]) begin
                    chk($sformatf("hold_valid%0d", i), sv[i], 1);
                    chk($sformatf("hold_bit%0d", i), sb[i], hold_b[i]);
                end
                hold_v[i] = 1'b0;
                if (sv[i]) begin
                    if (sbq[i].size() == 0) begin
                        chk($sformatf("extra_bit%0d", i), sv[i], 0);
                    end else if (rdy) begin
                        e = sbq[i].pop_front();
                        chk($sformatf("bit%0d", i), sb[i], e[1]);
                        chk($sformatf("last%0d", i), sl[i], e[0]);
                        exp_done[i] = e[0];
                    end else begin
                        hold_v[i] = 1'b1;
                        hold_b[i] = sb[i];
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int k;
        k = 0;
        while (!lr[0] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("load_ready_wait", lr[0], 1);
        data = d;
        sign = s;
        load = 1'b1;
        push(d, s);
        @(posedge clk); #1;
        load = 1'b0;
        data = 8'($urandom);
        sign = 1'($urandom);
    endtask

    task automatic wait_idle(input bit rnd);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sv == 2'b00) break;
            if (rnd) rdy = 1'($urandom_range(0, 1));
        end
        rdy = 1'b1;
        chk("frame_timeout", 32'(k < 300), 1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; sign = 1'b0; rdy = 1'b1;
        #2;
        chk("rst_valid", sv, 0);
        chk("rst_bit",   sb, 0);
        chk("rst_last",  sl, 0);
        chk("rst_busy",  bz, 0);
        chk("rst_done",  dn, 0);
        chk("rst_ready", lr, 2'b11);
        @(posedge clk); #1;
        rst = 1'b0;

        send(8'hA5, 1'b1); wait_idle(1'b0);
        send(8'h81, 1'b0); wait_idle(1'b0);

        // back-pressure on the second serial bit
        send(8'h5A, 1'b1);
        @(posedge clk); #1;
        rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rdy = 1'b1;
        wait_idle(1'b0);

        // load mid-frame is ignored
        send(8'h3C, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_lr", lr, 2'b00);
        load = 1'b1; data = 8'hFF; sign = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_idle(1'b0);

        // load coinciding with final accept is ignored; next load in done cycle is taken
        send(8'h96, 1'b1);
        repeat (8 + PAR) begin @(posedge clk); #1; end
        chk("final_last", sl, 2'b11);
        load = 1'b1; data = 8'hFF; sign = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("done_cycle_valid", sv, 0);
        chk("done_cycle_lr", lr, 2'b11);
        send(8'hC3, 1'b0);
        chk("b2b_start", sv, 2'b11);
        wait_idle(1'b0);

        send(8'h07, 1'b1); wait_idle(1'b0);

        for (int n = 0; n < 4; n++) begin
            send(8'($urandom), 1'($urandom));
            wait_idle(1'b1);
        end

        // reset during the 4th data bit
        send(8'hE7, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", sv, 0);
        chk("mid_rst_busy",  bz, 0);
        chk("mid_rst_ready", lr, 2'b11);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("post_rst_valid", sv, 0);

        send(8'h3D, 1'b0); wait_idle(1'b0);
        @(posedge clk); #1;
        chk("sbq0_empty", sbq[0].size(), 0);
        chk("sbq1_empty", sbq[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
